// File: rtl/registro_estado_hist.sv
// FSM state register with a shift history of previous states, a dwell-cycle
// counter and a transition counter, all with saturation flags.
module registro_estado_hist #(
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] RESET_VAL  = '0,
    parameter int               HIST_DEPTH = 4,
    parameter int               DWELL_W    = 16,
    parameter int               TRANS_W    = 8
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              en,
    input  logic                              clr,
    input  logic [WIDTH-1:0]                  estado,
    output logic [WIDTH-1:0]                  estado_actual,
    output logic [HIST_DEPTH*WIDTH-1:0]       hist_flat,
    output logic [$clog2(HIST_DEPTH+1)-1:0]   hist_count,
    output logic                              cambio,
    output logic [DWELL_W-1:0]                dwell,
    output logic                              dwell_sat,
    output logic [TRANS_W-1:0]                trans_count,
    output logic                              trans_sat
);

    localparam int HC_W = $clog2(HIST_DEPTH+1);

    function automatic logic [DWELL_W-1:0] dwell_inc(input logic [DWELL_W-1:0] v);
        return (v == {DWELL_W{1'b1}}) ? v : v + DWELL_W'(1);
    endfunction

    function automatic logic [TRANS_W-1:0] trans_inc(input logic [TRANS_W-1:0] v);
        return (v == {TRANS_W{1'b1}}) ? v : v + TRANS_W'(1);
    endfunction

    function automatic logic [HC_W-1:0] hcount_inc(input logic [HC_W-1:0] v);
        return (v == HC_W'(HIST_DEPTH)) ? v : v + HC_W'(1);
    endfunction

    logic [WIDTH-1:0]   r_estado;
    logic [WIDTH-1:0]   r_hist [HIST_DEPTH];
    logic [HC_W-1:0]    r_hist_count;
    logic               r_cambio;
    logic [DWELL_W-1:0] r_dwell;
    logic               r_dwell_sat;
    logic [TRANS_W-1:0] r_trans;
    logic               r_trans_sat;

    logic               w_change;
    logic [DWELL_W-1:0] w_dwell_nxt;
    logic [TRANS_W-1:0] w_trans_nxt;

    // A reload of the value already held is a hold, not a change.
    assign w_change    = en && (estado != r_estado);
    assign w_dwell_nxt = dwell_inc(r_dwell);
    assign w_trans_nxt = trans_inc(r_trans);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_estado     <= RESET_VAL;
            for (int k = 0; k < HIST_DEPTH; k++) r_hist[k] <= RESET_VAL;
            r_hist_count <= '0;
            r_cambio     <= 1'b0;
            r_dwell      <= '0;
            r_dwell_sat  <= 1'b0;
            r_trans      <= '0;
            r_trans_sat  <= 1'b0;
        end else if (clr) begin
            r_estado     <= RESET_VAL;
            for (int k = 0; k < HIST_DEPTH; k++) r_hist[k] <= RESET_VAL;
            r_hist_count <= '0;
            r_cambio     <= 1'b0;
            r_dwell      <= '0;
            r_dwell_sat  <= 1'b0;
            r_trans      <= '0;
            r_trans_sat  <= 1'b0;
        end else if (w_change) begin
            r_estado     <= estado;
            r_hist[0]    <= r_estado;
            for (int k = 1; k < HIST_DEPTH; k++) r_hist[k] <= r_hist[k-1];
            r_hist_count <= hcount_inc(r_hist_count);
            r_cambio     <= 1'b1;
            r_dwell      <= '0;
            r_dwell_sat  <= 1'b0;
            r_trans      <= w_trans_nxt;
            r_trans_sat  <= (w_trans_nxt == {TRANS_W{1'b1}});
        end else begin
            r_cambio     <= 1'b0;
            r_dwell      <= w_dwell_nxt;
            r_dwell_sat  <= (w_dwell_nxt == {DWELL_W{1'b1}});
        end
    end

    always_comb begin
        hist_flat = '0;
        for (int k = 0; k < HIST_DEPTH; k++) hist_flat[k*WIDTH +: WIDTH] = r_hist[k];
    end

    assign estado_actual = r_estado;
    assign hist_count    = r_hist_count;
    assign cambio        = r_cambio;
    assign dwell         = r_dwell;
    assign dwell_sat     = r_dwell_sat;
    assign trans_count   = r_trans;
    assign trans_sat     = r_trans_sat;

endmodule

// File: tb/tb_registro_estado_hist.sv
// Bench for registro_estado_hist: two instances (default sizes, and a narrow
// one with HIST_DEPTH=1) driven in parallel and checked against a queue model.
module tb_registro_estado_hist;

    logic       clk    = 1'b0;
    logic       reset  = 1'b0;
    logic       en     = 1'b0;
    logic       clr    = 1'b0;
    logic [7:0] estado = 8'h00;

    logic [7:0]  estado_a, estado_b;
    logic [31:0] hist_a;
    logic [7:0]  hist_b;
    logic [2:0]  hcnt_a;
    logic [0:0]  hcnt_b;
    logic        cambio_a, cambio_b;
    logic [15:0] dwell_a;
    logic [3:0]  dwell_b;
    logic        dsat_a, dsat_b;
    logic [7:0]  trans_a;
    logic [2:0]  trans_b;
    logic        tsat_a, tsat_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    registro_estado_hist #(.WIDTH(8), .RESET_VAL(8'h00), .HIST_DEPTH(4), .DWELL_W(16), .TRANS_W(8)) dut_a (
        .clk(clk), .reset(reset), .en(en), .clr(clr), .estado(estado),
        .estado_actual(estado_a), .hist_flat(hist_a), .hist_count(hcnt_a), .cambio(cambio_a),
        .dwell(dwell_a), .dwell_sat(dsat_a), .trans_count(trans_a), .trans_sat(tsat_a));

    registro_estado_hist #(.WIDTH(8), .RESET_VAL(8'h00), .HIST_DEPTH(1), .DWELL_W(4), .TRANS_W(3)) dut_b (
        .clk(clk), .reset(reset), .en(en), .clr(clr), .estado(estado),
        .estado_actual(estado_b), .hist_flat(hist_b), .hist_count(hcnt_b), .cambio(cambio_b),
        .dwell(dwell_b), .dwell_sat(dsat_b), .trans_count(trans_b), .trans_sat(tsat_b));

    // Model: a log of previous states (newest first), plain integer counters.
    logic [7:0] m_cur = 8'h00;
    logic [7:0] m_log[$];
    int         m_dwell = 0;
    int         m_trans = 0;
    bit         m_cambio = 1'b0;

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cur = 8'h00;
        m_log.delete();
        m_dwell = 0;
        m_trans = 0;
        m_cambio = 1'b0;
    endtask

    task automatic model_step(input logic e, input logic c, input logic [7:0] s);
        if (c) begin
            model_reset();
        end else if (e && s != m_cur) begin
            m_log.push_front(m_cur);
            if (m_log.size() > 8) void'(m_log.pop_back());
            m_cur = s;
            m_trans++;
            m_dwell = 0;
            m_cambio = 1'b1;
        end else begin
            m_dwell++;
            m_cambio = 1'b0;
        end
    endtask

    function automatic logic [7:0] slot_exp(input int k);
        return (k < m_log.size()) ? m_log[k] : 8'h00;
    endfunction

    task automatic compare_all();
        int n;
        int dw, tr;
        n = m_log.size();
        check("A estado_actual", 64'(estado_a), 64'(m_cur));
        for (int k = 0; k < 4; k++)
            check($sformatf("A slot%0d", k), 64'(hist_a[k*8 +: 8]), 64'(slot_exp(k)));
        check("A hist_count", 64'(hcnt_a), 64'(imin(n, 4)));
        check("A cambio", 64'(cambio_a), 64'(m_cambio));
        dw = imin(m_dwell, 65535);
        tr = imin(m_trans, 255);
        check("A dwell", 64'(dwell_a), 64'(dw));
        check("A dwell_sat", 64'(dsat_a), 64'(dw == 65535));
        check("A trans_count", 64'(trans_a), 64'(tr));
        check("A trans_sat", 64'(tsat_a), 64'(tr == 255));
        check("B estado_actual", 64'(estado_b), 64'(m_cur));
        check("B slot0", 64'(hist_b), 64'(slot_exp(0)));
        check("B hist_count", 64'(hcnt_b), 64'(imin(n, 1)));
        check("B cambio", 64'(cambio_b), 64'(m_cambio));
        dw = imin(m_dwell, 15);
        tr = imin(m_trans, 7);
        check("B dwell", 64'(dwell_b), 64'(dw));
        check("B dwell_sat", 64'(dsat_b), 64'(dw == 15));
        check("B trans_count", 64'(trans_b), 64'(tr));
        check("B trans_sat", 64'(tsat_b), 64'(tr == 7));
    endtask

    // Model advances on every active edge or async reset, then compares 1 time unit later.
    initial forever begin
        @(posedge clk or negedge reset);
        if (!reset) model_reset();
        else model_step(en, clr, estado);
        #1;
        compare_all();
    end

    task automatic drive(input logic e, input logic c, input logic [7:0] s);
        @(negedge clk);
        en = e; clr = c; estado = s;
    endtask

    initial begin
        // Reset held for three edges, then released.
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("T1 dwell", 64'(dwell_a), 64'd3);
        check("T1 estado", 64'(estado_a), 64'h00);
        check("T1 hist_count", 64'(hcnt_a), 64'd0);
        check("T1 cambio", 64'(cambio_a), 64'd0);

        // Five consecutive changes.
        for (int i = 1; i <= 5; i++) drive(1'b1, 1'b0, 8'(i));
        @(negedge clk);
        check("T2 estado", 64'(estado_a), 64'h05);
        check("T2 hist", 64'(hist_a), 64'h01020304);
        check("T2 hist_count", 64'(hcnt_a), 64'd4);
        check("T2 trans", 64'(trans_a), 64'd5);
        check("T2 dwell", 64'(dwell_a), 64'd0);
        check("T2 cambio", 64'(cambio_a), 64'd1);

        // Reload of same value, then en low with a different value.
        repeat (10) @(negedge clk);
        check("T3 dwell10", 64'(dwell_a), 64'd10);
        check("T3 cambio", 64'(cambio_a), 64'd0);
        check("T3 hist", 64'(hist_a), 64'h01020304);
        en = 1'b0; estado = 8'hAA;
        repeat (3) @(negedge clk);
        check("T3 dwell13", 64'(dwell_a), 64'd13);
        check("T3 estado", 64'(estado_a), 64'h05);

        // clr wins over a simultaneous change.
        en = 1'b1; clr = 1'b1; estado = 8'h33;
        @(negedge clk);
        check("T6 clr estado", 64'(estado_a), 64'h00);
        check("T6 clr hist_count", 64'(hcnt_a), 64'd0);
        check("T6 clr trans", 64'(trans_a), 64'd0);
        check("T6 clr cambio", 64'(cambio_a), 64'd0);
        check("T6 clr hist", 64'(hist_a), 64'h0);
        en = 1'b0; clr = 1'b0;

        // Dwell saturation on the 4-bit instance.
        repeat (14) @(negedge clk);
        check("T4 dwell14", 64'(dwell_b), 64'd14);
        check("T4 sat14", 64'(dsat_b), 64'd0);
        @(negedge clk);
        check("T4 dwell15", 64'(dwell_b), 64'd15);
        check("T4 sat15", 64'(dsat_b), 64'd1);
        repeat (5) @(negedge clk);
        check("T4 dwell20", 64'(dwell_b), 64'd15);
        check("T4 sat20", 64'(dsat_b), 64'd1);
        en = 1'b1; estado = 8'h07;
        @(negedge clk);
        check("T4 dwell clr", 64'(dwell_b), 64'd0);
        check("T4 sat clr", 64'(dsat_b), 64'd0);

        // Transition-count saturation on the 3-bit instance.
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            en = 1'b1; estado = 8'(8'h10 + i);
            @(negedge clk);
            check($sformatf("T5 B trans after %0d", i), 64'(trans_b), 64'(imin(i, 7)));
            check($sformatf("T5 B sat after %0d", i), 64'(tsat_b), 64'(i >= 7));
            check($sformatf("T5 A trans after %0d", i), 64'(trans_a), 64'(i));
        end
        check("T5 B slot0", 64'(hist_b), 64'h18);

        // Asynchronous reset between edges during a change sequence.
        estado = 8'h20;
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("T6 async estado", 64'(estado_a), 64'h00);
        check("T6 async trans", 64'(trans_a), 64'd0);
        check("T6 async hist_count", 64'(hcnt_a), 64'd0);
        check("T6 async cambio", 64'(cambio_a), 64'd0);
        check("T6 async B trans", 64'(trans_b), 64'd0);
        @(negedge clk);
        reset = 1'b1; en = 1'b0;

        // Randomised traffic over a small state alphabet.
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                @(posedge clk);
                #2 reset = 1'b0;
                @(negedge clk);
                reset = 1'b1;
            end else begin
                drive(($urandom_range(0, 3) != 0), ($urandom_range(0, 39) == 0), 8'($urandom_range(0, 3)));
            end
        end
        en = 1'b0; clr = 1'b0;
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/registro_estado_hist.md
Name: registro_estado_hist

Overview:
Parametrised successor of the FSM state register. It holds the current state with a load enable and a synchronous clear, keeps a shift history of the last HIST_DEPTH distinct previous states, and counts both cycles spent in the current state and total state transitions. It sits between each FSM's next-state logic and its output logic. It also feeds the maintenance/diagnostic counters that read dwell time and transition count.

Parameters:
WIDTH, 8, state code width in bits
RESET_VAL, 0, state loaded on reset and on clr (WIDTH bits)
HIST_DEPTH, 4, number of previous states retained (>=1)
DWELL_W, 16, width of dwell-cycle counter
TRANS_W, 8, width of transition counter

Ports:
clk  in  1  clock; all state changes on rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
en  in  1  load enable for estado
clr  in  1  synchronous clear to reset values; takes priority over en
estado  in  WIDTH  next-state input
estado_actual  out  WIDTH  registered current state
hist_flat  out  HIST_DEPTH*WIDTH  history; slot k at bits [k*WIDTH +: WIDTH]; slot 0 = most recent previous state
hist_count  out  $clog2(HIST_DEPTH+1)  number of valid history slots
cambio  out  1  one-cycle pulse, high the cycle after a state change
dwell  out  DWELL_W  cycles since last change (or since reset/clr)
dwell_sat  out  1  dwell has reached all-ones
trans_count  out  TRANS_W  number of accepted state changes
trans_sat  out  1  trans_count has reached all-ones

Behaviour:
- Reset (reset=0, asynchronous): estado_actual=RESET_VAL; all history slots=RESET_VAL; hist_count=0; cambio=0; dwell=0; dwell_sat=0; trans_count=0; trans_sat=0. Outputs hold these values while reset=0. They are released on the first clk edge after reset returns to 1.
- All outputs are registered. Effects of inputs appear one clk after the sampling edge.
- Per-edge priority: clr, then change, then hold.
- clr=1: every output loads its reset value, regardless of en or estado.
- Change: en=1, clr=0 and estado != estado_actual.
  - estado_actual<=estado.
  - Slot 0<=old estado_actual; slot k<=slot k-1 for k=1..HIST_DEPTH-1; oldest slot is discarded.
  - hist_count increments, saturating at HIST_DEPTH.
  - cambio<=1; dwell<=0; dwell_sat<=0.
  - trans_count increments, saturating at all-ones; trans_sat<=1 when the new value is all-ones.
- Hold: en=0, or en=1 with estado == estado_actual (a reload of the same value is not a change).
  - estado_actual, history, hist_count and trans_count are unchanged.
  - cambio<=0.
  - dwell increments, saturating at all-ones, no wrap. dwell_sat<=1 when the new value is all-ones.
- cambio is never high for two consecutive cycles unless a change is accepted on consecutive edges.
- Width rules: counters are unsigned. Saturation compares against {W{1'b1}}. Inputs are never truncated; estado is exactly WIDTH bits.
- HIST_DEPTH=1: history is a single previous-state register with the same rules.
- Reset asserted mid-operation overrides everything immediately, including a pending change on the same edge.

Test Plan:
1. WIDTH=8, RESET_VAL=8'h00: reset=0 for 3 cycles, then release. Expect estado_actual=00, hist_count=0, dwell counting 1,2,3 from the first post-release edge, cambio=0.
2. en=1 with estado sequence 01,02,03,04,05 on consecutive edges. After the last edge expect:
   - estado_actual=05; slots 0..3 = 04,03,02,01; hist_count=4.
   - trans_count=5; cambio high for 5 consecutive cycles; dwell=0.
3. en=1, estado=estado_actual=05 for 10 cycles. Expect no cambio, history unchanged, dwell=10. Then en=0 with estado=AA for 3 cycles: expect estado_actual still 05, dwell=13.
4. With DWELL_W=4, hold for 20 cycles. Expect dwell=15 and dwell_sat=1 from the 15th cycle on. A change then clears both to 0 on the next edge.
5. With TRANS_W=3, perform 9 changes. Expect trans_count=7 with trans_sat=1 after the 7th change, unchanged after the 8th and 9th.
6. Apply clr=1 and en=1 with estado=33 on the same edge: expect reset values and cambio=0. Then assert reset=0 asynchronously between edges during a change sequence: outputs go to reset values before the next clk edge.
